// File: rtl/shift_out.sv
// rtl/shift_out.sv - reassembles four 16-lane quarter results into one 64-lane wavefront word
module shift_out #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*WIDTH-1:0]   data_in,
  input  logic                  in_valid,
  input  logic                  in_first,
  output logic [64*WIDTH-1:0]   data_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [1:0]            quarter_cnt,
  output logic                  seq_err
);

  localparam int QW = 16 * WIDTH;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t              state_q;
  logic [48*WIDTH-1:0] staging_q;
  logic [64*WIDTH-1:0] data_out_q;
  logic [1:0]          cnt_q;
  logic                out_valid_q;
  logic                seq_err_q;
  logic                busy_q;

  // Quarter collection FSM: staging, completion, abort and violation flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      staging_q   <= '0;
      data_out_q  <= '0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Both flags are single-cycle pulses unless re-raised below
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_first) begin
              staging_q[QW-1:0] <= data_in;
              cnt_q             <= 2'd1;
              busy_q            <= 1'b1;
              state_q           <= COLLECT;
            end else begin
              // Continuation beat with no wavefront open: drop it
              seq_err_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (in_first) begin
              // Restart: partial wavefront discarded, this beat is the new quarter 0
              seq_err_q         <= 1'b1;
              staging_q[QW-1:0] <= data_in;
              cnt_q             <= 2'd1;
            end else if (cnt_q == 2'd3) begin
              data_out_q  <= {data_in, staging_q};
              out_valid_q <= 1'b1;
              cnt_q       <= 2'd0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              if (cnt_q == 2'd1) begin
                staging_q[2*QW-1:QW] <= data_in;
              end else begin
                staging_q[3*QW-1:2*QW] <= data_in;
              end
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign quarter_cnt = cnt_q;
  assign seq_err     = seq_err_q;

endmodule
